// File: rtl/craft_pkg.sv
// CRAFT key schedule shared definitions: FSM states, LFSR seeds, the Q
// nibble permutation used on the tweak, and helpers shared by the top and
// the round-constant generator.
// Optional feature macro: CRAFT_KS_PRECOMP_EN (see craft_key_schedule.sv).
package craft_pkg;

   // Default number of rounds per block; legal range is 1..32
   localparam int ROUNDS_DEFAULT = 32;

   // Seeds loaded into the round-constant LFSRs when a schedule starts
   localparam logic [3:0] A_INIT = 4'h1;
   localparam logic [2:0] B_INIT = 3'h1;

   // Q(T) nibble i takes tweak nibble Q_PERM[i]; nibble 0 is the top nibble
   localparam int Q_PERM [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

   // Schedule controller states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ksState_e;

   // Apply the Q nibble permutation to a 64-bit tweak
   function automatic logic [63:0] qPermute(input logic [63:0] t);
      logic [63:0] q;
      q = '0;
      for (int i = 0; i < 16; i++) begin
         q[63-4*i -: 4] = t[63-4*Q_PERM[i] -: 4];
      end
      return q;
   endfunction

   // One step of the 4-bit round-constant LFSR (period 15)
   function automatic logic [3:0] stepA(input logic [3:0] a);
      return {a[0] ^ a[1], a[3:1]};
   endfunction

   // One step of the 3-bit round-constant LFSR (period 7)
   function automatic logic [2:0] stepB(input logic [2:0] b);
      return {b[0] ^ b[1], b[2:1]};
   endfunction

   // Round constant byte layout: {a, 0, b}
   function automatic logic [7:0] packRc(input logic [3:0] a, input logic [2:0] b);
      return {a, 1'b0, b};
   endfunction

endpackage

// File: rtl/craft_rc_lfsr.sv
// Round-constant generator for the CRAFT key schedule: two small LFSRs
// that are reseeded on load and advanced once per accepted round.
// Optional feature macro: none used in this file.
module craft_rc_lfsr
   import craft_pkg::*;
(
   input  logic       clk_i,
   input  logic       rstN_i,
   input  logic       ce_i,
   input  logic       load_i,
   input  logic       step_i,
   output logic [7:0] rc_o
);

   logic [3:0] a_q;
   logic [2:0] b_q;

   // Reseed on load, advance on step; load wins so a restart always begins at round 0
   always_ff @(posedge clk_i) begin
      if (!rstN_i) begin
         a_q <= A_INIT;
         b_q <= B_INIT;
      end else if (ce_i) begin
         if (load_i) begin
            a_q <= A_INIT;
            b_q <= B_INIT;
         end else if (step_i) begin
            a_q <= stepA(a_q);
            b_q <= stepB(b_q);
         end
      end
   end

   assign rc_o = packRc(a_q, b_q);

endmodule

// File: rtl/craft_key_schedule.sv
// CRAFT key schedule: latches a 128-bit key and 64-bit tweak on start and
// then presents one round tweakey and round constant per accepted round.
// Optional feature macro: CRAFT_KS_PRECOMP_EN -- when defined, the four
// tweakeys are computed once at start and held in registers; otherwise
// only K0, K1 and T are held and the tweakey is rebuilt every cycle.
module craft_key_schedule
   import craft_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
)(
   input  logic         CLK,
   input  logic         RST,
   input  logic         CE,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [63:0]  tweak,
   input  logic         next,
   output logic [63:0]  tk,
   output logic [7:0]   rc,
   output logic [4:0]   round,
   output logic         valid,
   output logic         last,
   output logic         done
);

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

   ksState_e   state_q;
   logic [4:0] round_q;
   logic       done_q;

   logic       atLast;
   logic       stepRound;
   logic [63:0] tkSel;
   logic [7:0]  rcRaw;

   assign atLast    = (round_q == LAST_ROUND);
   assign stepRound = (state_q == RUN) && next && !start && !atLast;

   // Schedule controller: start restarts from round 0 in any state, next
   // advances in RUN, and accepting the final round returns to IDLE with a
   // single done pulse
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         round_q <= 5'd0;
         done_q  <= 1'b0;
      end else if (CE) begin
         done_q <= 1'b0;
         if (start) begin
            state_q <= RUN;
            round_q <= 5'd0;
         end else if ((state_q == RUN) && next) begin
            if (atLast) begin
               state_q <= IDLE;
               round_q <= 5'd0;
               done_q  <= 1'b1;
            end else begin
               round_q <= round_q + 5'd1;
            end
         end
      end
   end

   craft_rc_lfsr u_rcLfsr (
      .clk_i  (CLK),
      .rstN_i (RST),
      .ce_i   (CE),
      .load_i (start),
      .step_i (stepRound),
      .rc_o   (rcRaw)
   );

`ifdef CRAFT_KS_PRECOMP_EN
   logic [63:0] tkReg_q [4];

   // Build all four tweakeys once when a schedule is loaded
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < 4; i++) begin
            tkReg_q[i] <= '0;
         end
      end else if (CE && start) begin
         tkReg_q[0] <= key[127:64] ^ tweak;
         tkReg_q[1] <= key[63:0]   ^ tweak;
         tkReg_q[2] <= key[127:64] ^ qPermute(tweak);
         tkReg_q[3] <= key[63:0]   ^ qPermute(tweak);
      end
   end

   assign tkSel = tkReg_q[round_q[1:0]];
`else
   logic [63:0] k0_q;
   logic [63:0] k1_q;
   logic [63:0] t_q;
   logic [63:0] qT;

   // Hold only the raw key halves and tweak; tweakeys are rebuilt each cycle
   always_ff @(posedge CLK) begin
      if (!RST) begin
         k0_q <= '0;
         k1_q <= '0;
         t_q  <= '0;
      end else if (CE && start) begin
         k0_q <= key[127:64];
         k1_q <= key[63:0];
         t_q  <= tweak;
      end
   end

   assign qT = qPermute(t_q);

   // Select the tweakey for this round from the stored key halves and tweak
   always_comb begin
      tkSel = '0;
      case (round_q[1:0])
         2'd0:    tkSel = k0_q ^ t_q;
         2'd1:    tkSel = k1_q ^ t_q;
         2'd2:    tkSel = k0_q ^ qT;
         default: tkSel = k1_q ^ qT;
      endcase
   end
`endif

   assign valid = (state_q == RUN);
   assign tk    = valid ? tkSel   : 64'd0;
   assign rc    = valid ? rcRaw   : 8'd0;
   assign round = valid ? round_q : 5'd0;
   assign last  = valid && atLast;
   assign done  = done_q;

endmodule

// File: tb/tb_craft_key_schedule.sv
// Self-checking bench for craft_key_schedule: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that works
// from round number, key and tweak rather than from LFSR/register state.
module tb_craft_key_schedule;

   localparam int R = 32;

   logic         CLK = 1'b0;
   logic         RST;
   logic         CE;
   logic         start;
   logic [127:0] key;
   logic [63:0]  tweak;
   logic         next;
   logic [63:0]  tk;
   logic [7:0]   rc;
   logic [4:0]   round;
   logic         valid;
   logic         last;
   logic         done;

   int testsRun    = 0;
   int testsFailed = 0;

   // model state
   bit           mRun;
   int           mRound;
   bit           mDone;
   logic [127:0] mKey;
   logic [63:0]  mTweak;

   craft_key_schedule #(.ROUNDS(R)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .CE    (CE),
      .start (start),
      .key   (key),
      .tweak (tweak),
      .next  (next),
      .tk    (tk),
      .rc    (rc),
      .round (round),
      .valid (valid),
      .last  (last),
      .done  (done)
   );

   // free-running clock
   always #5 CLK = ~CLK;

   // round constant nibble a after r steps from the seed
   function automatic logic [3:0] aAt(input int r);
      logic [3:0] a;
      a = 4'h1;
      for (int i = 0; i < r; i++) a = {a[0] ^ a[1], a[3:1]};
      return a;
   endfunction

   function automatic logic [2:0] bAt(input int r);
      logic [2:0] b;
      b = 3'h1;
      for (int i = 0; i < r; i++) b = {b[0] ^ b[1], b[2:1]};
      return b;
   endfunction

   function automatic logic [63:0] qOf(input logic [63:0] t);
      int         p [16];
      logic [3:0] nib [16];
      logic [63:0] q;
      p = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
      q = '0;
      for (int i = 0; i < 16; i++) nib[i] = t[63-4*i -: 4];
      for (int i = 0; i < 16; i++) q[63-4*i -: 4] = nib[p[i]];
      return q;
   endfunction

   function automatic logic [63:0] tkModel(input logic [127:0] k, input logic [63:0] t, input int r);
      case (r % 4)
         0:       return k[127:64] ^ t;
         1:       return k[63:0]   ^ t;
         2:       return k[127:64] ^ qOf(t);
         default: return k[63:0]   ^ qOf(t);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // compare every output against the model's view of the current cycle
   task automatic compareAll(input string tag);
      checkOutput({tag, ".valid"}, 64'(valid), 64'(mRun));
      checkOutput({tag, ".round"}, 64'(round), mRun ? 64'(mRound) : 64'd0);
      checkOutput({tag, ".rc"},    64'(rc),
                  mRun ? 64'({aAt(mRound), 1'b0, bAt(mRound)}) : 64'd0);
      checkOutput({tag, ".tk"},    tk, mRun ? tkModel(mKey, mTweak, mRound) : 64'd0);
      checkOutput({tag, ".last"},  64'(last), 64'(mRun && (mRound == R - 1)));
      checkOutput({tag, ".done"},  64'(done), 64'(mDone));
   endtask

   // drive one cycle of inputs, advance the model across the coming edge, then check
   task automatic applyStimulus(input string tag, input bit rstN, input bit ce, input bit st,
                                input bit nx, input logic [127:0] k, input logic [63:0] t);
      RST = rstN; CE = ce; start = st; next = nx; key = k; tweak = t;
      if (!rstN) begin
         mRun = 0; mRound = 0; mDone = 0;
      end else if (ce) begin
         mDone = 0;
         if (st) begin
            mRun = 1; mRound = 0; mKey = k; mTweak = t;
         end else if (mRun && nx) begin
            if (mRound == R - 1) begin
               mRun = 0; mRound = 0; mDone = 1;
            end else begin
               mRound++;
            end
         end
      end
      @(negedge CLK);
      compareAll(tag);
   endtask

   logic [127:0] rk;
   logic [63:0]  rt;

   initial begin
      RST = 1'b0; CE = 1'b1; start = 1'b0; next = 1'b0; key = '0; tweak = '0;
      mRun = 0; mRound = 0; mDone = 0; mKey = '0; mTweak = '0;
      @(negedge CLK);

      // reset state
      applyStimulus("reset", 0, 1, 0, 0, '0, '0);
      applyStimulus("reset", 0, 0, 1, 1, '1, '1);
      checkOutput("reset_valid", 64'(valid), 64'd0);
      checkOutput("reset_tk", tk, 64'd0);

      // zero key/tweak: rc sequence and zero tweakey
      applyStimulus("zero", 1, 1, 1, 0, '0, '0);
      checkOutput("zero_rc0", 64'(rc), 64'h11);
      applyStimulus("zero", 1, 1, 0, 1, '0, '0);
      checkOutput("zero_rc1", 64'(rc), 64'h84);
      applyStimulus("zero", 1, 1, 0, 1, '0, '0);
      checkOutput("zero_rc2", 64'(rc), 64'h42);
      applyStimulus("zero", 1, 1, 0, 1, '0, '0);
      checkOutput("zero_rc3", 64'(rc), 64'h25);
      checkOutput("zero_tk3", tk, 64'd0);

      // known tweak vector
      applyStimulus("kat", 1, 1, 1, 0, '0, 64'h0123456789ABCDEF);
      checkOutput("kat_tk0", tk, 64'h0123456789ABCDEF);
      applyStimulus("kat", 1, 1, 0, 1, '0, '0);
      applyStimulus("kat", 1, 1, 0, 1, '0, '0);
      checkOutput("kat_tk2", tk, 64'hCAF5E892B374601D);

      // full run with random key/tweak, including last round and done pulse
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom};
      applyStimulus("full", 1, 1, 1, 0, rk, rt);
      for (int i = 1; i < R; i++) begin
         applyStimulus("full", 1, 1, 0, 1, '0, '0);
         if (i == 4) checkOutput("full_tk4", tk, rk[127:64] ^ rt);
      end
      checkOutput("full_rc31", 64'(rc), 64'h85);
      checkOutput("full_last31", 64'(last), 64'd1);
      applyStimulus("full_end", 1, 1, 0, 1, '0, '0);
      checkOutput("full_done", 64'(done), 64'd1);
      checkOutput("full_valid", 64'(valid), 64'd0);
      applyStimulus("full_idle", 1, 1, 0, 1, '0, '0);
      checkOutput("full_done_pulse", 64'(done), 64'd0);

      // restart mid-schedule at round 10
      applyStimulus("restart", 1, 1, 1, 0, rk, rt);
      for (int i = 0; i < 10; i++) applyStimulus("restart", 1, 1, 0, 1, '0, '0);
      checkOutput("restart_r10", 64'(round), 64'd10);
      rt = ~rt;
      applyStimulus("restart", 1, 1, 1, 1, ~rk, rt);
      checkOutput("restart_round", 64'(round), 64'd0);
      checkOutput("restart_rc", 64'(rc), 64'h11);
      checkOutput("restart_tk", tk, rk[127:64] ^ 64'hFFFF_FFFF_FFFF_FFFF ^ rt);
      checkOutput("restart_done", 64'(done), 64'd0);

      // clock enable freeze at round 5, then reset mid-run
      for (int i = 0; i < 5; i++) applyStimulus("ce", 1, 1, 0, 1, '0, '0);
      for (int i = 0; i < 3; i++) applyStimulus("ce_hold", 1, 0, 1, 1, '1, '1);
      checkOutput("ce_round", 64'(round), 64'd5);
      applyStimulus("midrst", 0, 1, 0, 1, '0, '0);
      checkOutput("midrst_valid", 64'(valid), 64'd0);
      checkOutput("midrst_rc", 64'(rc), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus("rand",
                       ($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 59) == 0),
                       ($urandom_range(0, 1) == 1),
                       {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/craft_key_schedule.md
CRAFT_KEY_SCHEDULE -- requirements
Module: craft_key_schedule

Interface
REQ-001 Parameter ROUNDS, default 32, number of cipher rounds per block (legal 1..32).
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  synchronous reset, active-low.
REQ-004 CE  input  1  clock enable; when low all state SHALL hold.
REQ-005 start  input  1  load key/tweak and begin a schedule.
REQ-006 key  input  128  K0 = key[127:64], K1 = key[63:0].
REQ-007 tweak  input  64  tweak T; nibble 0 = tweak[63:60].
REQ-008 next  input  1  consumer accepted current round material; advance.
REQ-009 tk  output  64  round tweakey for the current round.
REQ-010 rc  output  8  round constant {a[3:0], 1'b0, b[2:0]}.
REQ-011 round  output  5  current round index.
REQ-012 valid  output  1  tk/rc/round are valid.
REQ-013 last  output  1  valid and round == ROUNDS-1.
REQ-014 done  output  1  one-cycle pulse after the last round is accepted.

Function
REQ-015 States IDLE and RUN; updates SHALL occur only on CLK edges with CE=1.
REQ-016 start=1 in any state SHALL latch key and tweak, set round=0, a=4'h1, b=3'h1, and enter RUN; valid=1 from the next cycle.
REQ-017 start SHALL take priority over next in the same cycle (restart mid-schedule discards the old schedule, no done pulse).
REQ-018 In RUN, next=1 with round<ROUNDS-1 SHALL increment round and step both LFSRs; next=0 holds all outputs stable.
REQ-019 In RUN, next=1 with round==ROUNDS-1 SHALL enter IDLE, clear valid, and assert done for exactly one cycle.
REQ-020 next in IDLE SHALL be ignored.
REQ-021 LFSR a step: a <= {a[0]^a[1], a[3:1]} (period 15: 1,8,4,2,9,C,6,B,...).
REQ-022 LFSR b step: b <= {b[0]^b[1], b[2:1]} (period 7: 1,4,2,5,6,7,3).
REQ-023 Q nibble permutation: Q(T) nibble i = T nibble P[i], P = 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
REQ-024 tk SHALL be K0^T, K1^T, K0^Q(T), K1^Q(T) for round mod 4 = 0,1,2,3.
REQ-025 When valid=0, tk, rc and round SHALL be driven to zero.
REQ-026 tk/rc SHALL be a direct function of registered state (no combinational path from key/tweak inputs to outputs).

Reset
REQ-027 RST=0 at a CLK edge SHALL force IDLE, valid=0, done=0, last=0, round=0, tk=0, rc=0, regardless of CE, start, or operation in progress.

Configuration
REQ-028 Macro CRAFT_KS_PRECOMP_EN defined: the four tweakeys SHALL be computed and stored in four 64-bit registers at start; tk is a 4:1 mux of those registers.
REQ-029 Macro undefined: only K0, K1, T SHALL be stored; Q(T) and the XOR SHALL be computed each cycle; port-level behaviour identical, cycle for cycle.

Structure
REQ-030 Shared package craft_pkg SHALL hold the Q permutation table, LFSR initial values, ROUNDS default, and rc packing function.
REQ-031 One sub-module craft_rc_lfsr (a/b LFSRs, load/step inputs, rc output) SHALL be instantiated.

Verification
REQ-032 key=0, tweak=0, start, then next every cycle -> rc 8'h11, 8'h84, 8'h42, 8'h25 for rounds 0..3; tk=0 throughout.
REQ-033 key=0, tweak=64'h0123456789ABCDEF -> tk round0 = 64'h0123456789ABCDEF, round2 = 64'hCAF5E892B374601D.
REQ-034 Full 32-round run -> round 31 has rc=8'h85 and last=1; next -> valid=0 and a single done pulse; round 4 repeats round 0 tk.
REQ-035 start asserted at round 10 with next=1 -> round=0, rc=8'h11, new tk; no done pulse.
REQ-036 CE=0 for 3 cycles with next=1 at round 5 -> outputs frozen; RST=0 mid-run -> IDLE, all outputs zero next cycle; both macro settings give identical traces.
